// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM step codes and
// instruction-register field positions.
package alu_seq_pkg;

  // Opcodes; the ALU subset uses the same codes as the msALU operation select.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INV = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_MV  = 3'b110,
    OP_MVI = 3'b111
  } opcode_e;

  // Controller steps; T0 is idle.
  typedef logic [1:0] state_t;
  localparam state_t ST_T0 = 2'd0;
  localparam state_t ST_T1 = 2'd1;
  localparam state_t ST_T2 = 2'd2;
  localparam state_t ST_T3 = 2'd3;

  // Instruction register layout: [8:6] opcode, [5:3] Rx, [2:0] Ry.
  localparam int IR_W     = 9;
  localparam int IR_OP_HI = 8;
  localparam int IR_OP_LO = 6;
  localparam int IR_RX_HI = 5;
  localparam int IR_RX_LO = 3;
  localparam int IR_RY_HI = 2;
  localparam int IR_RY_LO = 0;

  // True for the two-operand ALU operations that take the three-step path.
  function automatic logic is_alu3(opcode_e op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_decode3to8.sv
// One-hot register select decoder with enable; all outputs low when disabled.
module reg_decode3to8 #(
  parameter int N = 8
) (
  input  logic         en_i,
  input  logic [2:0]   idx_i,
  output logic [N-1:0] onehot_o
);

  // Decode the register index into a single active select line.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = N'(1) << idx_i;
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the shared-bus datapath (register file, msALU,
// DIN). Accepts one instruction per Run in T0 and sequences T1..T3.
// Optional build macro SEQ_INSTR_COUNT_EN adds a retired-instruction counter;
// without it InstrCount is tied to zero.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                CLKb,
  input  logic                Resetn,
  input  logic                Run,
  input  logic [DATA_W-1:0]   DIN,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                DINout,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic [2:0]          ALUControl,
  output logic                Done,
  output logic                Busy,
  output logic [CNT_W-1:0]    InstrCount
);

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  opcode_e           op_s;
  logic [2:0]        rx_s, ry_s, rout_idx_s;
  logic              rin_en_s, rout_en_s;
  logic              unused_din_s;

  assign op_s = opcode_e'(ir_q[IR_OP_HI:IR_OP_LO]);
  assign rx_s = ir_q[IR_RX_HI:IR_RX_LO];
  assign ry_s = ir_q[IR_RY_HI:IR_RY_LO];
  // Bits of DIN above the instruction field carry no meaning in T0.
  assign unused_din_s = ^DIN[DATA_W-1:IR_W];

  // Step and instruction-register update; reset aborts any instruction.
  always_ff @(posedge CLKb or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-step selection; Run only matters while idle.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_T0: begin
        if (Run) begin
          state_d = ST_T1;
          ir_d    = DIN[IR_W-1:0];
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T1: begin
        if (op_s == OP_MV || op_s == OP_MVI) state_d = ST_T0;
        else                                 state_d = ST_T2;
      end
      ST_T2: begin
        if (op_s == OP_INV) state_d = ST_T0;
        else                state_d = ST_T3;
      end
      ST_T3:   state_d = ST_T0;
      default: state_d = ST_T0;
    endcase
  end

  // Datapath strobes as a pure function of step and instruction.
  always_comb begin
    rin_en_s   = 1'b0;
    rout_en_s  = 1'b0;
    rout_idx_s = 3'd0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    Done       = 1'b0;
    ALUControl = 3'b000;
    case (state_q)
      ST_T1: begin
        case (op_s)
          OP_INV: begin
            rout_en_s  = 1'b1;
            rout_idx_s = ry_s;
            Gin        = 1'b1;
            ALUControl = ir_q[IR_OP_HI:IR_OP_LO];
          end
          OP_MV: begin
            rout_en_s  = 1'b1;
            rout_idx_s = ry_s;
            rin_en_s   = 1'b1;
            Done       = 1'b1;
          end
          OP_MVI: begin
            DINout   = 1'b1;
            rin_en_s = 1'b1;
            Done     = 1'b1;
          end
          default: begin
            rout_en_s  = 1'b1;
            rout_idx_s = rx_s;
            Ain        = 1'b1;
            ALUControl = ir_q[IR_OP_HI:IR_OP_LO];
          end
        endcase
      end
      ST_T2: begin
        if (op_s == OP_INV) begin
          Gout       = 1'b1;
          rin_en_s   = 1'b1;
          Done       = 1'b1;
          ALUControl = ir_q[IR_OP_HI:IR_OP_LO];
        end else if (is_alu3(op_s)) begin
          rout_en_s  = 1'b1;
          rout_idx_s = ry_s;
          Gin        = 1'b1;
          ALUControl = ir_q[IR_OP_HI:IR_OP_LO];
        end else begin
          Done = 1'b0;
        end
      end
      ST_T3: begin
        if (is_alu3(op_s)) begin
          Gout       = 1'b1;
          rin_en_s   = 1'b1;
          Done       = 1'b1;
          ALUControl = ir_q[IR_OP_HI:IR_OP_LO];
        end else begin
          Done = 1'b0;
        end
      end
      default: Done = 1'b0;
    endcase
  end

  assign Busy = (state_q != ST_T0);

  reg_decode3to8 #(.N(NUM_REGS)) u_rin_dec (
    .en_i     (rin_en_s),
    .idx_i    (rx_s),
    .onehot_o (Rin)
  );

  reg_decode3to8 #(.N(NUM_REGS)) u_rout_dec (
    .en_i     (rout_en_s),
    .idx_i    (rout_idx_s),
    .onehot_o (Rout)
  );

`ifdef SEQ_INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count each retiring instruction, wrapping naturally at full scale.
  always_ff @(posedge CLKb or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else if (Done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign InstrCount = cnt_q;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural shared-bus datapath
// (register file plus msALU sampling on negedge) driven by the DUT strobes,
// checked against an instruction-level register model.
module tb_alu_sequencer;

  localparam int DATA_W   = 10;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 2;

  logic                CLKb = 1'b0;
  logic                Resetn = 1'b0;
  logic                Run = 1'b0;
  logic [DATA_W-1:0]   DIN = '0;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic                DINout, Ain, Gin, Gout, Done, Busy;
  logic [2:0]          ALUControl;
  logic [CNT_W-1:0]    InstrCount;

  alu_sequencer #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
    .CLKb(CLKb), .Resetn(Resetn), .Run(Run), .DIN(DIN),
    .Rin(Rin), .Rout(Rout), .DINout(DINout), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .ALUControl(ALUControl), .Done(Done), .Busy(Busy),
    .InstrCount(InstrCount)
  );

  always #5 CLKb = ~CLKb;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // ---------------- behavioural datapath ----------------
  logic [DATA_W-1:0] R [NUM_REGS];
  logic [DATA_W-1:0] A_r = '0, G_r = '0, bus_s;

  function automatic logic [DATA_W-1:0] alu_f(logic [2:0] c, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return ~b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    bus_s = '0;
    if (DINout) bus_s = bus_s | DIN;
    if (Gout)   bus_s = bus_s | G_r;
    for (int i = 0; i < NUM_REGS; i++) if (Rout[i]) bus_s = bus_s | R[i];
  end

  always @(negedge CLKb) begin
    if (Ain) A_r <= bus_s;
    if (Gin) G_r <= alu_f(ALUControl, A_r, bus_s);
    for (int i = 0; i < NUM_REGS; i++) if (Rin[i]) R[i] <= bus_s;
  end

  // ---------------- instruction-level model ----------------
  function automatic logic [DATA_W-1:0] model_f(logic [2:0] op, logic [DATA_W-1:0] x,
                                                logic [DATA_W-1:0] y, logic [DATA_W-1:0] imm);
    case (op)
      3'b110:  return y;
      3'b111:  return imm;
      default: return alu_f(op, x, y);
    endcase
  endfunction

  function automatic int lat_f(logic [2:0] op);
    if (op == 3'b110 || op == 3'b111) return 1;
    if (op == 3'b010) return 2;
    return 3;
  endfunction

  function automatic logic [24:0] outs();
    return {Rin, Rout, DINout, Ain, Gin, Gout, ALUControl, Done, Busy};
  endfunction

  function automatic logic [24:0] mk(logic [7:0] rin, logic [7:0] rout, logic dinout, logic ain,
                                     logic gin, logic gout, logic [2:0] alu, logic done, logic busy);
    return {rin, rout, dinout, ain, gin, gout, alu, done, busy};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKb);
    #1;
  endtask

  task automatic retire();
`ifdef SEQ_INSTR_COUNT_EN
    exp_cnt = exp_cnt + 2'd1;
`endif
  endtask

  // Issue one instruction from T0, follow it to completion, check the result.
  task automatic run_instr(logic [2:0] op, logic [2:0] rx, logic [2:0] ry, logic [DATA_W-1:0] imm);
    logic [DATA_W-1:0] expv;
    int  cyc;
    logic seen;
    expv = model_f(op, R[rx], R[ry], imm);
    Run = 1'b1;
    DIN = {1'($urandom_range(0, 1)), op, rx, ry};
    tick();
    DIN = imm;
    Run = 1'($urandom_range(0, 1));
    cyc = 0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc++;
      chk("busy", 32'(Busy), 32'd1);
      chk("bus_excl", 32'(($countones(Rout) + int'(DINout) + int'(Gout)) <= 1), 32'd1);
      chk("rin_only_done", 32'((Rin != '0) && !Done), 32'd0);
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
      Run = 1'($urandom_range(0, 1));
      if (op != 3'b111) DIN = DATA_W'($urandom);
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", 32'(cyc), 32'(lat_f(op)));
    tick();
    Run = 1'b0;
    retire();
    chk("idle_after", 32'(outs()), 32'd0);
    chk("result", 32'(R[rx]), 32'(expv));
    chk("count", 32'(InstrCount), 32'(exp_cnt));
  endtask

  typedef struct {
    logic [2:0]        op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [DATA_W-1:0] imm;
    int                cycles;
    logic [DATA_W-1:0] val;
  } vec_t;

  vec_t vt [13];
  logic [CNT_W-1:0] cnt_tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] saved;
    int lat_seen;
    vt[0]  = '{3'b111, 3'd1, 3'd0, 10'h005, 1, 10'h005};
    vt[1]  = '{3'b111, 3'd2, 3'd0, 10'h007, 1, 10'h007};
    vt[2]  = '{3'b000, 3'd1, 3'd2, 10'h000, 3, 10'h00C};
    vt[3]  = '{3'b001, 3'd2, 3'd1, 10'h000, 3, 10'h3FB};
    vt[4]  = '{3'b011, 3'd1, 3'd2, 10'h000, 3, 10'h008};
    vt[5]  = '{3'b100, 3'd1, 3'd2, 10'h000, 3, 10'h3FB};
    vt[6]  = '{3'b101, 3'd1, 3'd2, 10'h000, 3, 10'h000};
    vt[7]  = '{3'b111, 3'd0, 3'd0, 10'h000, 1, 10'h000};
    vt[8]  = '{3'b010, 3'd4, 3'd0, 10'h000, 2, 10'h3FF};
    vt[9]  = '{3'b110, 3'd5, 3'd4, 10'h000, 1, 10'h3FF};
    vt[10] = '{3'b000, 3'd5, 3'd5, 10'h000, 3, 10'h3FE};
    vt[11] = '{3'b111, 3'd7, 3'd0, 10'h2AA, 1, 10'h2AA};
    vt[12] = '{3'b110, 3'd3, 3'd7, 10'h000, 1, 10'h2AA};
`ifdef SEQ_INSTR_COUNT_EN
    cnt_tbl = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
    cnt_tbl = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Reset held two cycles, then five idle cycles.
    tick();
    tick();
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_cnt", 32'(InstrCount), 32'd0);
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outs", 32'(outs()), 32'd0);
    end

    // MVI R3,#0x155 step by step.
    Run = 1'b1;
    DIN = 10'b0_111_011_000;
    tick();
    Run = 1'b0;
    DIN = 10'h155;
    chk("mvi_t1", 32'(outs()), 32'(mk(8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1)));
    tick();
    retire();
    chk("mvi_idle", 32'(outs()), 32'd0);
    chk("mvi_r3", 32'(R[3]), 32'h155);
    chk("mvi_cnt", 32'(InstrCount), 32'(exp_cnt));

    // Table of instructions with constant expected results and latencies.
    for (int i = 0; i < 13; i++) begin
      Run = 1'b1;
      DIN = {1'b1, vt[i].op, vt[i].rx, vt[i].ry};
      tick();
      Run = 1'b0;
      DIN = vt[i].imm;
      lat_seen = 0;
      for (int k = 0; k < 8; k++) begin
        lat_seen++;
        if (Done === 1'b1) break;
        tick();
      end
      tick();
      retire();
      chk("tbl_latency", 32'(lat_seen), 32'(vt[i].cycles));
      chk("tbl_value", 32'(R[vt[i].rx]), 32'(vt[i].val));
    end

    // ADD R1,R2 with R1=5, R2=7, step by step.
    run_instr(3'b111, 3'd1, 3'd0, 10'h005);
    run_instr(3'b111, 3'd2, 3'd0, 10'h007);
    Run = 1'b1;
    DIN = 10'b0_000_001_010;
    tick();
    Run = 1'b0;
    chk("add_t1", 32'(outs()), 32'(mk(8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1)));
    tick();
    chk("add_t2", 32'(outs()), 32'(mk(8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1)));
    tick();
    chk("add_t3", 32'(outs()), 32'(mk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1)));
    tick();
    retire();
    chk("add_idle", 32'(outs()), 32'd0);
    chk("add_r1", 32'(R[1]), 32'h00C);
    chk("add_cnt", 32'(InstrCount), 32'(exp_cnt));

    // INV R4,R0 with R0=0; Run pulsed during T1 must be ignored.
    run_instr(3'b111, 3'd0, 3'd0, 10'h000);
    Run = 1'b1;
    DIN = 10'b0_010_100_000;
    tick();
    chk("inv_t1", 32'(outs()), 32'(mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1)));
    tick();
    Run = 1'b0;
    chk("inv_t2", 32'(outs()), 32'(mk(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1)));
    tick();
    retire();
    chk("inv_idle", 32'(outs()), 32'd0);
    tick();
    chk("inv_run_ignored", 32'(outs()), 32'd0);
    chk("inv_r4", 32'(R[4]), 32'h3FF);

    // Reset during T2 of SUB R2,R1.
    saved = R[2];
    Run = 1'b1;
    DIN = 10'b0_001_010_001;
    tick();
    Run = 1'b0;
    chk("sub_t1", 32'(outs()), 32'(mk(8'h00, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1)));
    tick();
    #1;
    Resetn = 1'b0;
    #1;
    chk("sub_reset_outs", 32'(outs()), 32'd0);
    tick();
    tick();
    Resetn = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_idle", 32'(outs()), 32'd0);
    end
    chk("sub_aborted_r2", 32'(R[2]), 32'(saved));
    chk("post_reset_cnt", 32'(InstrCount), 32'd0);
    run_instr(3'b111, 3'd6, 3'd0, 10'h0AB);
    run_instr(3'b110, 3'd5, 3'd6, 10'h000);
    chk("mv_r5", 32'(R[5]), 32'h0AB);

    // Counter wrap over five back-to-back MVs from a fresh reset.
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    exp_cnt = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      run_instr(3'b110, 3'(i), 3'(i + 1), 10'h000);
      chk("cnt_seq", 32'(InstrCount), 32'(cnt_tbl[i]));
    end

    // Randomised instructions against the register model.
    for (int i = 0; i < NUM_REGS; i++) run_instr(3'b111, 3'(i), 3'd0, DATA_W'($urandom));
    for (int i = 0; i < 60; i++) begin
      run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                DATA_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
